// File: rtl/seg7_scan_display.sv
// Multiplexed N-digit hex seven-segment scanner with frame-synchronous capture,
// per-digit decimal points, leading-zero blanking and an anode dead-time.
module seg7_scan_display #(
    parameter int N_DIGITS    = 4,
    parameter int DIV_COUNT   = 50000,
    parameter int DEAD_CYCLES = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [6:0]            hex,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   AN,
    output logic                  frame_start
);

    localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_val;
    logic [N_DIGITS-1:0]   r_dpin;
    logic                  r_lz;
    logic [6:0]            r_hex;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_fs;

    logic                  w_cnt_wrap;
    logic                  w_capture;
    logic                  w_dead;
    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic [N_DIGITS-1:0]   w_blank_mask;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic                  w_dp_lit;
    logic [N_DIGITS-1:0]   w_an_on;

    assign w_cnt_wrap = (r_cnt == CNT_MAX);
    assign w_capture  = w_cnt_wrap && (r_idx == IDX_MAX);
    assign w_dead     = (int'(r_cnt) < DEAD_CYCLES);

    // A digit above 0 is blanked only if it and every more-significant nibble is zero.
    always_comb begin
        w_blank_mask = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            w_blank_mask[k] = r_lz;
            for (int j = k; j < N_DIGITS; j++) begin
                if (r_val[j*4 +: 4] != 4'd0) begin
                    w_blank_mask[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_nib    = 4'd0;
        w_dp_bit = 1'b0;
        w_blank  = 1'b0;
        w_an_on  = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib      = r_val[k*4 +: 4];
                w_dp_bit   = r_dpin[k];
                w_blank    = w_blank_mask[k];
                w_an_on[k] = !w_dead;
            end
        end
        w_seg    = w_blank ? 7'h00 : seg_decode(w_nib);
        w_dp_lit = w_dp_bit && !w_blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_val  <= '0;
            r_dpin <= '0;
            r_lz   <= 1'b0;
            r_hex  <= {7{POL}};
            r_dp   <= POL;
            r_an   <= {N_DIGITS{POL}};
            r_fs   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
            // Shadow loads only at the frame boundary so a frame never mixes values.
            if (w_capture) begin
                r_val  <= value;
                r_dpin <= dp_in;
                r_lz   <= lz_blank;
            end
            r_hex <= w_seg ^ {7{POL}};
            r_dp  <= w_dp_lit ^ POL;
            r_an  <= w_an_on ^ {N_DIGITS{POL}};
            r_fs  <= (r_cnt == '0) && (r_idx == '0);
        end
    end

    assign hex         = r_hex;
    assign dp          = r_dp;
    assign AN          = r_an;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed table-driven bench for seg7_scan_display (4 digits, 4 cycles/slot,
// 1 dead cycle, active-low outputs).
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  hex;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_display #(
        .N_DIGITS(4), .DIV_COUNT(4), .DEAD_CYCLES(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
        .hex(hex), .dp(dp), .AN(AN), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        lz;
        logic [27:0] hex;   // {digit3, digit2, digit1, digit0}, active-low
        logic [3:0]  dp;    // per-digit dp output level, active-low
        string       name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic sync_frame(input string nm);
        int n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_sync: got no frame_start expected pulse within 40 cycles", nm);
        end
    endtask

    // Checks one full 16-cycle frame starting at a frame_start negedge; optionally
    // changes value partway through to confirm the frame is tear-free.
    task automatic check_frame(input logic [27:0] ehex, input logic [3:0] edp,
                               input int chg_at, input logic [15:0] chg_val,
                               input string nm);
        logic [3:0] exp_an;
        int d;
        int c;
        sync_frame(nm);
        for (int i = 0; i < 16; i++) begin
            if (i == chg_at) value = chg_val;
            d = i / 4;
            c = i % 4;
            exp_an = (c == 0) ? 4'hF : ~(4'b0001 << d);
            chk({nm, "_an"},  32'(AN),          32'(exp_an));
            chk({nm, "_hex"}, 32'(hex),         32'(ehex[d*7 +: 7]));
            chk({nm, "_dp"},  32'(dp),          32'(edp[d]));
            chk({nm, "_fs"},  32'(frame_start), 32'(i == 0));
            @(negedge clk);
        end
    endtask

    task automatic apply_and_check(input vec_t v);
        value    = v.value;
        dp_in    = v.dp_in;
        lz_blank = v.lz;
        sync_frame(v.name);
        @(negedge clk);
        check_frame(v.hex, v.dp, -1, 16'h0, v.name);
    endtask

    initial begin
        int dead_n;
        int fs_n;
        int bad_n;

        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111, "v12AF"};
        vecs[1] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, "v1234"};
        vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, "lz0050"};
        vecs[3] = '{16'h0050, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100, "lz0050dp"};
        vecs[4] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, "lz0000dp2"};
        vecs[5] = '{16'h0000, 4'b0100, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1011, "nolz0000dp2"};
        vecs[6] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110, "lz0000dp0"};
        vecs[7] = '{16'h0A00, 4'b0000, 1'b1, {7'h7F, 7'h08, 7'h40, 7'h40}, 4'b1111, "lz0A00"};
        vecs[8] = '{16'hBCDE, 4'b1010, 1'b1, {7'h03, 7'h46, 7'h21, 7'h06}, 4'b0101, "vBCDE"};

        rst      = 1'b1;
        value    = 16'hFFFF;
        dp_in    = 4'hF;
        lz_blank = 1'b0;
        #1;
        chk("rst_an",  32'(AN),          32'hF);
        chk("rst_hex", 32'(hex),         32'h7F);
        chk("rst_dp",  32'(dp),          32'h1);
        chk("rst_fs",  32'(frame_start), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_fs", 32'(frame_start), 32'h1);
        // Inputs are nonzero, but the first frame must show the cleared shadow.
        check_frame({4{7'h40}}, 4'hF, -1, 16'h0, "first_frame");

        foreach (vecs[i]) apply_and_check(vecs[i]);

        // Mid-frame change stays invisible until the next frame_start.
        value    = 16'h1234;
        dp_in    = 4'h0;
        lz_blank = 1'b0;
        sync_frame("midchg");
        @(negedge clk);
        check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 6, 16'h5678, "midchg_old");
        check_frame({7'h12, 7'h02, 7'h78, 7'h00}, 4'hF, -1, 16'h0, "midchg_new");

        // Long-run one-hot / dead-time / frame_start rate.
        dead_n = 0;
        fs_n   = 0;
        bad_n  = 0;
        sync_frame("onehot");
        for (int i = 0; i < 1000; i++) begin
            if (AN == 4'hF) dead_n++;
            if ($countones(~AN) > 1) bad_n++;
            if (frame_start) fs_n++;
            if ((AN == 4'hF) != (i % 4 == 0)) bad_n++;
            @(negedge clk);
        end
        chk("onehot_viol", 32'(bad_n),  32'd0);
        chk("dead_count",  32'(dead_n), 32'd250);
        chk("fs_count",    32'(fs_n),   32'd63);

        // Asynchronous reset while digit 0 is enabled and lit.
        value = 16'hBCDE;
        sync_frame("midrst");
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_an", 32'(AN), 32'hE);
        #2 rst = 1'b1;
        #1;
        chk("midrst_an",  32'(AN),  32'hF);
        chk("midrst_hex", 32'(hex), 32'h7F);
        chk("midrst_dp",  32'(dp),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_fs", 32'(frame_start), 32'h1);
        check_frame({4{7'h40}}, 4'hF, -1, 16'h0, "after_rst_frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
